pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised, flow-controlled pipeline register that succeeds the fixed ID/EX latch: one generic stage carrying an arbitrary packed payload (control word, operands, register IDs) with valid/ready handshake, stall, flush-to-bubble and an optional two-entry skid buffer. It is instantiated at every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It also keeps a saturating bubble counter for performance debug.

## Interface
- DATA_W, 40: payload width in bits; the payload is the packed stage bundle.
- SKID, 1: 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- CNT_W, 16: bubble counter width.
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream holds a payload.
- in_ready  out  1  stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  kill all held payloads; synchronous.
- out_valid  out  1  out_data is a live payload.
- out_ready  in  1  downstream consumes this cycle; deasserting it is the stall.
- out_data  out  DATA_W  payload to the next stage.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

## Operation
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Storage: main entry (drives out_*), plus a skid entry when SKID=1. Each entry has a valid bit and a data register.
- State (SKID=1):
  - EMPTY (main invalid)
  - FULL (main valid, skid invalid)
  - SKIDDED (both valid)
- Transitions (SKID=1):
  - EMPTY + input transfer -> FULL.
  - FULL + input without output -> SKIDDED. The new payload goes to skid.
  - FULL + input with output -> FULL. The new payload replaces main.
  - FULL + output only -> EMPTY.
  - SKIDDED + output -> FULL. Skid moves to main; no input is possible because in_ready=0.
- in_ready (SKID=1) = !skid_valid, driven directly from a flop.
- SKID=0:
  - Main entry only.
  - in_ready = !main_valid || out_ready (combinational path from out_ready).
  - Main loads on every input transfer.
- Bubble rule: out_data is all-zero whenever out_valid=0. Data registers are zeroed whenever their valid clears, so a zero control word always means NOP downstream.
- Flush:
  - All valid bits clear and all data registers zero on the next edge.
  - A payload accepted in the flush cycle is discarded; in_ready is not modified by flush in that cycle.
  - The output transfer in the flush cycle still counts as consumed.
- Priority: reset > flush > normal.
- bubble_cnt:
  - Increments when out_ready && !out_valid.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; flush does not clear it.
- No payload is ever duplicated, dropped (except by flush), or reordered.

## Timing
- Reset values:
  - out_valid=0
  - out_data=0
  - bubble_cnt=0
  - in_ready=1 in both modes; for SKID=0 this follows from main_valid=0.
  - All internal valids 0.
- Latency: one cycle from input transfer to out_valid when the stage is EMPTY.
- Throughput: one payload per cycle while out_ready=1.
- SKID=1 recovery:
  - After out_ready drops, at most one further input is absorbed into skid.
  - in_ready falls on the following edge.
  - in_ready re-asserts on the edge after the skid drains.
- Flush and reset take effect on the edge where they are sampled high. Outputs show the empty state in the next cycle.
- Reset mid-stream loses all payloads; the counter restarts from 0.

## Structure
- Package Defs:
  - Add the `PIPE_DATA_W` constants per boundary (e.g. `ID_EX_W`).
  - Add the packed bundle typedefs (e.g. `id_ex_bundle_t` = ControlSignals + RsVal, RdVal, ImmVal + Rs, Rd).
  - Callers cast the bundles to and from in_data/out_data.
- The entry-control logic lives in pipe_stage itself.
- One sub-module: sat_counter (parameter W; ports inc, clk, reset, count), used for bubble_cnt.
- Generate-if on SKID selects the skid path.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 and in_data=0xA5 -> out_valid=0, out_data=0, bubble_cnt=0, in_ready=1.
- Streaming, SKID=1: out_ready=1, push 0x01..0x08 back-to-back -> out_data shows 0x01..0x08 on consecutive cycles, one cycle after each input.
- Stall and skid, SKID=1:
  - Setup: main=0x11, out_ready=0, push 0x22.
  - Expect in_ready=0 next cycle and out_data held at 0x11.
  - Release out_ready -> 0x11 then 0x22, no loss.
- Flush:
  - Setup: stage SKIDDED (0x33, 0x44), assert flush with in_valid=1 and in_data=0x55.
  - Expect out_valid=0 and out_data=0 next cycle; 0x55 never appears.
  - bubble_cnt keeps its value.
- SKID=0 back-pressure:
  - Setup: out_ready=0 with main full.
  - Expect in_ready=0 in the same cycle.
  - Simultaneous in/out transfer replaces the payload with no bubble.
- Counter saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt reaches 15 and holds.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// Shared pipeline definitions: per-boundary payload bundles and their widths.
// Callers cast these bundles to and from pipe_stage in_data_i/out_data_o.
package pipe_stage_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ID_W       = 5;
    localparam int unsigned PIPE_DATA_W_DEF = 40;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSlt,
        AluSll,
        AluSrl
    } alu_op_e;

    // An all-zero control word must decode as a NOP downstream.
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_bundle_t;

    typedef struct packed {
        ctrl_t               ctrl;
        logic [XLEN-1:0]     rs_val;
        logic [XLEN-1:0]     rd_val;
        logic [XLEN-1:0]     imm_val;
        logic [REG_ID_W-1:0] rs;
        logic [REG_ID_W-1:0] rd;
    } id_ex_bundle_t;

    typedef struct packed {
        ctrl_t               ctrl;
        logic [XLEN-1:0]     alu_res;
        logic [XLEN-1:0]     store_val;
        logic [REG_ID_W-1:0] rd;
    } ex_mem_bundle_t;

    typedef struct packed {
        ctrl_t               ctrl;
        logic [XLEN-1:0]     wb_val;
        logic [REG_ID_W-1:0] rd;
    } mem_wb_bundle_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_bundle_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_bundle_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_bundle_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_bundle_t);

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_stage.sv
// Generic flow-controlled pipeline register with flush-to-bubble, optional
// two-entry skid buffer and a saturating bubble counter.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W_DEF,
    parameter bit          SKID   = 1'b1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid_i && in_ready;
    assign out_fire = main_valid_q && out_ready_i;

    if (SKID) begin : g_skid
        logic              skid_valid_q, skid_valid_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;

        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (flush_i) begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
                skid_valid_d = 1'b0;
                skid_data_d  = '0;
            end else if (!main_valid_q) begin
                if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data_i;
                end
            end else if (skid_valid_q) begin
                // in_ready is low here, so only the drain can happen.
                if (out_fire) begin
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_data_d  = '0;
                end
            end else if (in_fire && out_fire) begin
                main_data_d = in_data_i;
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end

        assign in_ready = !skid_valid_q;
    end else begin : g_noskid
        always_comb begin
            main_valid_d = main_valid_q;
            main_data_d  = main_data_q;
            if (flush_i) begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end else if (out_fire) begin
                main_valid_d = 1'b0;
                main_data_d  = '0;
            end
        end

        assign in_ready = !main_valid_q || out_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .inc_i  (out_ready_i && !main_valid_q),
        .count_o(bubble_cnt_o)
    );

    assign in_ready_o  = in_ready;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: skid, no-skid and small-counter instances.
module tb_pipe_stage;

    localparam int unsigned DW = 40;

    logic clk = 1'b0;
    logic reset;

    // Instance A: SKID=1, CNT_W=16
    logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [15:0]   a_bubble;
    // Instance B: SKID=0, CNT_W=16
    logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [15:0]   b_bubble;
    // Instance C: SKID=1, CNT_W=4
    logic          c_in_valid, c_in_ready, c_flush, c_out_valid, c_out_ready;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [3:0]    c_bubble;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stage #(.DATA_W(DW), .SKID(1'b1), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .reset_i(reset), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .in_data_i(a_in_data), .flush_i(a_flush), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .out_data_o(a_out_data), .bubble_cnt_o(a_bubble)
    );

    pipe_stage #(.DATA_W(DW), .SKID(1'b0), .CNT_W(16)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_data_i(b_in_data), .flush_i(b_flush), .out_valid_o(b_out_valid),
        .out_ready_i(b_out_ready), .out_data_o(b_out_data), .bubble_cnt_o(b_bubble)
    );

    pipe_stage #(.DATA_W(DW), .SKID(1'b1), .CNT_W(4)) u_dut_c (
        .clk_i(clk), .reset_i(reset), .in_valid_i(c_in_valid), .in_ready_o(c_in_ready),
        .in_data_i(c_in_data), .flush_i(c_flush), .out_valid_o(c_out_valid),
        .out_ready_i(c_out_ready), .out_data_o(c_out_data), .bubble_cnt_o(c_bubble)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b1; a_in_data = 40'hA5; a_flush = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 40'hA5; b_flush = 1'b0; b_out_ready = 1'b0;
        c_in_valid = 1'b1; c_in_data = 40'hA5; c_flush = 1'b0; c_out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check_eq("rst_a_out_data", 64'(a_out_data), 64'd0);
        check_eq("rst_a_bubble", 64'(a_bubble), 64'd0);
        check_eq("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check_eq("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check_eq("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        reset = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;

        // Streaming through A; the first edge is a bubble (out_ready=1, empty).
        a_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = DW'(i);
            tick();
            check_eq($sformatf("stream_valid_%0d", i), 64'(a_out_valid), 64'd1);
            check_eq($sformatf("stream_data_%0d", i), 64'(a_out_data), 64'(i));
        end
        a_in_valid = 1'b0;
        tick();
        check_eq("stream_drained", 64'(a_out_valid), 64'd0);
        check_eq("stream_drained_data", 64'(a_out_data), 64'd0);
        a_out_ready = 1'b0;
        check_eq("stream_bubble", 64'(a_bubble), 64'd1);

        // Stall and skid on A.
        a_in_valid = 1'b1; a_in_data = 40'h11;
        tick();
        a_in_data = 40'h22;
        tick();
        check_eq("skid_in_ready", 64'(a_in_ready), 64'd0);
        check_eq("skid_hold_data", 64'(a_out_data), 64'h11);
        a_in_data = 40'h99;     // offered while in_ready=0, must not enter
        tick();
        check_eq("skid_hold_data2", 64'(a_out_data), 64'h11);
        check_eq("skid_in_ready2", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        check_eq("release_first", 64'(a_out_data), 64'h11);
        tick();
        check_eq("release_second", 64'(a_out_data), 64'h22);
        check_eq("release_valid", 64'(a_out_valid), 64'd1);
        check_eq("release_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        check_eq("release_empty", 64'(a_out_valid), 64'd0);
        a_out_ready = 1'b0;
        check_eq("release_bubble", 64'(a_bubble), 64'd1);

        // Flush from SKIDDED with an offered payload.
        a_in_valid = 1'b1; a_in_data = 40'h33;
        tick();
        a_in_data = 40'h44;
        tick();
        check_eq("pre_flush_in_ready", 64'(a_in_ready), 64'd0);
        a_flush = 1'b1; a_in_data = 40'h55; a_out_ready = 1'b1;
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        check_eq("flush_valid", 64'(a_out_valid), 64'd0);
        check_eq("flush_data", 64'(a_out_data), 64'd0);
        check_eq("flush_in_ready", 64'(a_in_ready), 64'd1);
        check_eq("flush_bubble_kept", 64'(a_bubble), 64'd1);
        tick();
        check_eq("flush_no_55", 64'(a_out_valid), 64'd0);

        // Flush from FULL: payload accepted in the flush cycle is discarded.
        a_in_valid = 1'b1; a_in_data = 40'h66;
        tick();
        a_flush = 1'b1; a_in_data = 40'h77;
        check_eq("flush2_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check_eq("flush2_valid", 64'(a_out_valid), 64'd0);
        check_eq("flush2_data", 64'(a_out_data), 64'd0);
        tick();
        check_eq("flush2_no_77", 64'(a_out_valid), 64'd0);

        // SKID=0 back-pressure on B.
        b_in_valid = 1'b1; b_in_data = 40'h10;
        tick();
        check_eq("ns_load", 64'(b_out_data), 64'h10);
        b_in_data = 40'h20;
        #1;
        check_eq("ns_in_ready_stall", 64'(b_in_ready), 64'd0);
        b_out_ready = 1'b1;
        #1;
        check_eq("ns_in_ready_go", 64'(b_in_ready), 64'd1);
        tick();
        check_eq("ns_replace_valid", 64'(b_out_valid), 64'd1);
        check_eq("ns_replace_data", 64'(b_out_data), 64'h20);
        check_eq("ns_no_bubble", 64'(b_bubble), 64'd0);
        b_in_valid = 1'b0;
        tick();
        check_eq("ns_empty", 64'(b_out_valid), 64'd0);
        check_eq("ns_empty_data", 64'(b_out_data), 64'd0);
        tick();
        check_eq("ns_bubble", 64'(b_bubble), 64'd1);
        b_out_ready = 1'b0;

        // Counter saturation on C.
        c_out_ready = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check_eq("sat_14", 64'(c_bubble), 64'd14);
        tick();
        check_eq("sat_15", 64'(c_bubble), 64'd15);
        for (int i = 0; i < 5; i++) tick();
        check_eq("sat_hold", 64'(c_bubble), 64'd15);

        // Reset mid-stream clears payload and counter.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst2_c_bubble", 64'(c_bubble), 64'd0);
        check_eq("rst2_a_valid", 64'(a_out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
